config_loader: RTL and testbench
================================

Name: config_loader

Overview:
- Writer side of the fabric configuration chain. Takes a byte-wide bitstream over a valid/ready handshake and checks its header and checksum.
- Serialises the payload into the shift chain that feeds every logic element's config_in field.
- Holds the fabric in reset and disabled until a complete, verified load.
- Sits between the external programming interface and the top-level fabric.

Parameters:
- CHAIN_LENGTH, 20, total configuration bits in the fabric chain (>= 1).
- MAGIC, 8'hA5, required first byte of every bitstream.

Ports:
- clock  input  1  fabric clock; all logic is on the rising edge.
- nreset  input  1  synchronous, active-low reset.
- start  input  1  single-cycle pulse that begins a load.
- in_data  input  8  bitstream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts in_data this cycle.
- cfg_shift_en  output  1  chain shifts one bit this cycle.
- cfg_shift_data  output  1  bit shifted into the chain.
- fabric_nreset  output  1  reset to the fabric (active-low).
- fabric_enable  output  1  enable to every logic element.
- done  output  1  last load verified.
- error  output  1  last load rejected.

Behaviour:
- Handshake: a byte is accepted in a cycle where in_valid and in_ready are both 1. in_ready is combinational from state only, never from in_valid.
- PAYLOAD_BYTES = ceil(CHAIN_LENGTH/8). LAST_BITS = CHAIN_LENGTH mod 8, where 0 means 8.
- States:
  - IDLE: all outputs 0. start -> MAGIC.
  - MAGIC: in_ready=1. On accept, byte == MAGIC -> BYTE and clear the checksum; otherwise -> ERROR.
  - BYTE: in_ready=1. On accept, load the byte into an 8-bit shift register and XOR it into the checksum. Set bit count to 8, or LAST_BITS for the final payload byte. -> SHIFT.
  - SHIFT: in_ready=0. Each cycle: cfg_shift_en=1, cfg_shift_data = sreg[0], sreg shifts right, count and remaining-bits both decrement. When count reaches 0: remaining == 0 -> CHECK, else -> BYTE.
  - CHECK: in_ready=1. On accept, byte == checksum -> DONE, otherwise -> ERROR.
  - DONE: done=1, fabric_nreset=1, fabric_enable=1. start -> MAGIC, dropping all three in that same transition.
  - ERROR: error=1, fabric_nreset=0, fabric_enable=0. start -> MAGIC.
- Bit order: LSB first. Bit 0 of the first payload byte is the first bit shifted; the final chain bit is the last bit shifted.
- Unused high bits of the last payload byte are never shifted but are included in the checksum.
- Output timing: all outputs are registered or decoded from state, so each reflects state in the cycle after the transition. done, error and the fabric signals update in the first cycle of their state.
- Latency: one byte every 9 cycles minimum (1 accept + 8 shift). Exactly CHAIN_LENGTH cfg_shift_en pulses per successful load; the chain is never over- or under-shifted.
- Error stop: after an error, shifting stops immediately. The chain contents are undefined, but the fabric is held in reset.
- start outside IDLE/DONE/ERROR is ignored; loads are not aborted. start coincident with in_valid in DONE: the byte is not accepted that cycle.
- in_valid while in_ready=0: the byte is held off; no data is lost.
- Reset values (nreset=0 at any time, including mid-shift): state IDLE, all outputs 0, shift register, counters and checksum cleared.

Decomposition:
- Shared package holds the state enum, the MAGIC default, and the PAYLOAD_BYTES and LAST_BITS computation functions.
- No sub-module. The serialiser is a shift register plus counter kept inline.
- Remaining-bits counter width is $clog2(CHAIN_LENGTH+1).

Test Plan:
- Good load, CHAIN_LENGTH=20: start, then A5, 3C, 81, 0F, checksum B2.
  - cfg_shift_data sequence: 0,0,1,1,1,1,0,0, 1,0,0,0,0,0,0,1, 1,1,1,1.
  - Exactly 20 cfg_shift_en pulses.
  - done=1, fabric_nreset=1, fabric_enable=1 after B2 is accepted.
- Bad magic: start, then 5A -> error=1, zero shift pulses, fabric_nreset=0.
- Bad checksum: same payload, checksum B3 -> 20 shift pulses, then error=1, done=0, fabric_enable=0.
- Backpressure: hold in_valid=1 throughout.
  - in_ready=0 for 8 cycles after each payload accept (4 cycles after the third byte).
  - No byte is dropped or duplicated; shift output matches the good-load sequence.
- Reset mid-shift: assert nreset=0 on the 5th shift cycle of byte 2.
  - Next cycle: all outputs 0, state IDLE.
  - A fresh good load then passes.
- Reload from DONE: start pulse -> fabric_nreset and fabric_enable drop the next cycle. A second good load reasserts them.

Source files
------------

// File: rtl/config_loader_pkg.sv
// Shared types and sizing helpers for the fabric configuration loader.
package config_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAGIC,
    S_BYTE,
    S_SHIFT,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

  function automatic int payload_bytes(input int chain_length);
    return (chain_length + 7) / 8;
  endfunction

  // Bits actually shifted from the final payload byte; a full byte when the chain is a multiple of 8.
  function automatic int last_bits(input int chain_length);
    return ((chain_length % 8) == 0) ? 8 : (chain_length % 8);
  endfunction

endpackage

// File: rtl/config_loader.sv
// Bitstream writer for the fabric config chain: checks magic and XOR checksum,
// shifts the payload LSB-first and holds the fabric in reset until a verified load.
module config_loader
  import config_loader_pkg::*;
#(
  parameter int         CHAIN_LENGTH = 20,
  parameter logic [7:0] MAGIC        = MAGIC_DEFAULT
) (
  input  logic       clock,
  input  logic       nreset,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       cfg_shift_en,
  output logic       cfg_shift_data,
  output logic       fabric_nreset,
  output logic       fabric_enable,
  output logic       done,
  output logic       error
);

  localparam int         RW       = $clog2(CHAIN_LENGTH + 1);
  localparam logic [3:0] LAST_CNT = 4'(last_bits(CHAIN_LENGTH));

  state_t          state;
  state_t          next;
  logic [7:0]      sreg;
  logic [7:0]      csum;
  logic [3:0]      cnt;
  logic [RW-1:0]   rem;
  logic            accept;
  logic            final_byte;

  assign accept     = in_valid & in_ready;
  assign final_byte = (32'(rem) <= 32'd8);

  always_ff @(posedge clock) begin
    if (!nreset) state <= S_IDLE;
    else         state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      S_IDLE:  if (start) next = S_MAGIC;
      S_MAGIC: if (accept) next = (in_data == MAGIC) ? S_BYTE : S_ERROR;
      S_BYTE:  if (accept) next = S_SHIFT;
      S_SHIFT: if (cnt == 4'd1) next = (rem == RW'(1)) ? S_CHECK : S_BYTE;
      S_CHECK: if (accept) next = (in_data == csum) ? S_DONE : S_ERROR;
      S_DONE:  if (start) next = S_MAGIC;
      S_ERROR: if (start) next = S_MAGIC;
      default: next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready       = 1'b0;
    cfg_shift_en   = 1'b0;
    cfg_shift_data = 1'b0;
    fabric_nreset  = 1'b0;
    fabric_enable  = 1'b0;
    done           = 1'b0;
    error          = 1'b0;
    case (state)
      S_MAGIC, S_BYTE, S_CHECK: in_ready = 1'b1;
      S_SHIFT: begin
        cfg_shift_en   = 1'b1;
        cfg_shift_data = sreg[0];
      end
      S_DONE: begin
        done          = 1'b1;
        fabric_nreset = 1'b1;
        fabric_enable = 1'b1;
      end
      S_ERROR: error = 1'b1;
      default: ;
    endcase
  end

  // Serialiser: byte register, per-byte bit count and chain-wide remaining count.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      sreg <= '0;
      csum <= '0;
      cnt  <= '0;
      rem  <= '0;
    end else begin
      case (state)
        S_MAGIC: if (accept && in_data == MAGIC) begin
          csum <= '0;
          rem  <= RW'(CHAIN_LENGTH);
        end
        S_BYTE: if (accept) begin
          sreg <= in_data;
          csum <= csum ^ in_data;
          cnt  <= final_byte ? LAST_CNT : 4'd8;
        end
        S_SHIFT: begin
          sreg <= {1'b0, sreg[7:1]};
          cnt  <= cnt - 4'd1;
          rem  <= rem - RW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader with CHAIN_LENGTH=20 and payload 3C 81 0F.
module tb_config_loader;

  logic       clock = 1'b0;
  logic       nreset;
  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       cfg_shift_en;
  logic       cfg_shift_data;
  logic       fabric_nreset;
  logic       fabric_enable;
  logic       done;
  logic       error;

  int         tests = 0;
  int         fails = 0;
  int         shift_cnt;
  logic [63:0] shift_bits;
  int         stall [5];

  config_loader #(.CHAIN_LENGTH(20), .MAGIC(8'hA5)) dut (
    .clock(clock), .nreset(nreset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .cfg_shift_en(cfg_shift_en),
    .cfg_shift_data(cfg_shift_data), .fabric_nreset(fabric_nreset),
    .fabric_enable(fabric_enable), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Record each shifted bit in chain order.
  always @(negedge clock) begin
    if (cfg_shift_en) begin
      if (shift_cnt < 64) shift_bits[shift_cnt] = cfg_shift_data;
      shift_cnt = shift_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {in_ready, cfg_shift_en, cfg_shift_data, fabric_nreset, fabric_enable, done, error};
  endfunction

  task automatic clear_mon();
    shift_cnt  = 0;
    shift_bits = '0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Present a byte from a negedge and return at the negedge after it is accepted.
  task automatic send_byte(input logic [7:0] b, input bit hold, output int stalls);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
    else @(negedge clock);
    stalls = n;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic payload(input logic [7:0] csum, input bit hold);
    send_byte(8'h3C, hold, stall[1]);
    send_byte(8'h81, hold, stall[2]);
    send_byte(8'h0F, hold, stall[3]);
    send_byte(csum, hold, stall[4]);
  endtask

  initial begin
    nreset   = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    clear_mon();
    repeat (3) @(negedge clock);
    check("reset_outs", 32'(outs()), 32'd0);
    nreset = 1'b1;
    @(negedge clock);
    check("idle_outs", 32'(outs()), 32'd0);

    // Good load
    clear_mon();
    pulse_start();
    send_byte(8'hA5, 1'b0, stall[0]);
    payload(8'hB2, 1'b0);
    check("good_pulses", 32'(shift_cnt), 32'd20);
    check("good_bits", 32'(shift_bits[19:0]), 32'h000F813C);
    check("good_status", {28'd0, done, error, fabric_nreset, fabric_enable}, 32'b1011);

    // Reload from DONE with a byte already on the bus
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(negedge clock);
    start = 1'b0;
    check("reload_drop", {28'd0, done, fabric_nreset, fabric_enable, in_ready}, 32'b0001);
    clear_mon();
    send_byte(8'hA5, 1'b0, stall[0]);
    check("reload_magic_stall", 32'(stall[0]), 32'd0);
    payload(8'hB2, 1'b0);
    check("reload_pulses", 32'(shift_cnt), 32'd20);
    check("reload_status", {28'd0, done, error, fabric_nreset, fabric_enable}, 32'b1011);

    // Bad checksum
    clear_mon();
    pulse_start();
    send_byte(8'hA5, 1'b0, stall[0]);
    payload(8'hB3, 1'b0);
    check("badsum_pulses", 32'(shift_cnt), 32'd20);
    check("badsum_status", {28'd0, done, error, fabric_nreset, fabric_enable}, 32'b0100);

    // Bad magic
    clear_mon();
    pulse_start();
    send_byte(8'h5A, 1'b0, stall[0]);
    check("badmagic_status", {28'd0, done, error, fabric_nreset, fabric_enable}, 32'b0100);
    in_valid = 1'b1;
    in_data  = 8'h3C;
    repeat (10) @(negedge clock);
    in_valid = 1'b0;
    check("badmagic_pulses", 32'(shift_cnt), 32'd0);
    check("badmagic_hold", 32'(outs()), 32'b0000001);

    // Backpressure with in_valid held high throughout
    clear_mon();
    pulse_start();
    send_byte(8'hA5, 1'b1, stall[0]);
    payload(8'hB2, 1'b1);
    in_valid = 1'b0;
    check("bp_stall_b1", 32'(stall[1]), 32'd0);
    check("bp_stall_b2", 32'(stall[2]), 32'd8);
    check("bp_stall_b3", 32'(stall[3]), 32'd8);
    check("bp_stall_csum", 32'(stall[4]), 32'd4);
    check("bp_pulses", 32'(shift_cnt), 32'd20);
    check("bp_bits", 32'(shift_bits[19:0]), 32'h000F813C);
    check("bp_status", {28'd0, done, error, fabric_nreset, fabric_enable}, 32'b1011);

    // Reset on the 5th shift cycle of byte 2
    clear_mon();
    pulse_start();
    send_byte(8'hA5, 1'b0, stall[0]);
    send_byte(8'h3C, 1'b0, stall[1]);
    send_byte(8'h81, 1'b0, stall[2]);
    repeat (4) @(negedge clock);
    check("midshift_en", 32'(cfg_shift_en), 32'd1);
    nreset = 1'b0;
    @(negedge clock);
    check("midshift_reset_outs", 32'(outs()), 32'd0);
    check("midshift_pulses", 32'(shift_cnt), 32'd13);
    nreset = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (3) @(negedge clock);
    check("midshift_idle", 32'(outs()), 32'd0);
    in_valid = 1'b0;

    // Fresh good load after reset
    clear_mon();
    pulse_start();
    send_byte(8'hA5, 1'b0, stall[0]);
    payload(8'hB2, 1'b0);
    check("fresh_pulses", 32'(shift_cnt), 32'd20);
    check("fresh_bits", 32'(shift_bits[19:0]), 32'h000F813C);
    check("fresh_status", {28'd0, done, error, fabric_nreset, fabric_enable}, 32'b1011);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
